pulse_tap_sequencer: RTL and testbench
======================================

Name: pulse_tap_sequencer

Overview:
- Fast-clock-domain stage directly downstream of the slow-to-fast pulse collector; consumes its `fast_pulse` stream.
- Each accepted pulse means one new input window is ready. The block turns it into a burst of NUM_TAPS tap-index beats that drive the time-multiplexed MAC array.
- Pulses arriving during a burst are queued in a saturating pending counter. Bursts run back-to-back with no bubble.

Parameters:
- NUM_TAPS, 9, taps per window (3x3 kernel); legal range 1..2^TAP_W.
- TAP_W, 4, width of tap_idx.
- PEND_W, 4, width of pending-pulse counter; max queued = 2^PEND_W-1.

Ports:
- fast_clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- fast_pulse  in  1  one-cycle window-ready pulse from the collector; may be high on consecutive cycles.
- enable  in  1  downstream ready; low stalls the sequencer.
- ovf_clr  in  1  clears sticky overflow.
- tap_valid  out  1  tap beat valid this cycle.
- tap_idx  out  TAP_W  current tap index, 0..NUM_TAPS-1.
- tap_first  out  1  beat is tap 0 of a window.
- tap_last  out  1  beat is tap NUM_TAPS-1.
- win_done  out  1  one-cycle pulse, cycle after the last beat of a window.
- pend_cnt  out  PEND_W  queued, not-yet-started windows.
- overflow  out  1  sticky; a pulse was dropped.

Behaviour:
- Reset: rst sampled high at an edge forces the following to 0 next cycle, regardless of state:
  - state=IDLE, tap_idx, pend_cnt, win_done, overflow.
  - tap_valid, tap_first and tap_last are therefore 0.
  - Any in-flight window and all queued pulses are discarded.
- Registered state: state {IDLE, RUN}, tap_idx, pend_cnt, win_done, overflow.
- Combinational outputs:
  - tap_valid = (state==RUN) & enable.
  - tap_first = tap_valid & (tap_idx==0).
  - tap_last = tap_valid & (tap_idx==NUM_TAPS-1).
- Pending counter. Define start = window launched this edge.
  - pend_cnt_next = pend_cnt + inc - start, where inc = fast_pulse & !(pend_cnt==max & !start).
  - Pulse and start on the same edge: count unchanged.
  - Pulse at max with no start: pulse dropped, overflow<=1.
  - overflow clears only on rst or ovf_clr; a same-edge drop has priority over ovf_clr.
- IDLE:
  - If pend_cnt!=0 & enable: state<=RUN, tap_idx<=0, start=1.
  - Otherwise hold.
- RUN, enable=0: hold state and tap_idx; no beat, no start.
- RUN, enable=1, tap_idx<NUM_TAPS-1: tap_idx<=tap_idx+1.
- RUN, enable=1, tap_idx==NUM_TAPS-1 (last beat):
  - win_done<=1.
  - If pend_cnt!=0: tap_idx<=0, remain RUN, start=1. Next window's tap 0 is issued the very next enabled cycle.
  - Otherwise state<=IDLE, tap_idx<=0.
- win_done: high exactly one cycle after each last beat, else 0.
- Latency: pulse sampled at edge E with pend_cnt=0, state IDLE, enable=1 gives pend_cnt=1 after E and the tap 0 beat in the cycle after edge E+1 (two edges pulse-to-first-beat).
- NUM_TAPS=1: every beat has tap_first=tap_last=1, and tap_idx stays 0.
- tap_idx width arithmetic is wrap-free by construction; tap_idx never exceeds NUM_TAPS-1.
- The pend_cnt decision uses the registered value. A pulse on the last-beat edge is not eligible to launch on that same edge.

Test Plan:
- Single pulse, NUM_TAPS=9, enable=1: pulse at edge 0 -> pend_cnt=1 after edge 0; beats idx 0..8 in cycles 2..10; tap_first in cycle 2, tap_last in cycle 10; win_done in cycle 11; pend_cnt=0, IDLE.
- Three consecutive pulses, enable=1: 27 contiguous beats with no bubble; tap_first at beats 0, 9, 18; three win_done pulses; pend_cnt peaks at 2; ends IDLE.
- Stall: enable=0 for 4 cycles while tap_idx=5 -> tap_valid=0 and tap_idx holds 5; on enable=1, resumes at 5; window still totals 9 beats.
- Overflow, PEND_W=2, enable=0: 5 pulses -> pend_cnt saturates at 3, overflow=1; ovf_clr pulse -> overflow=0 while pend_cnt stays 3.
- Simultaneous: pulse on the same edge as a start with pend_cnt=3 (max) -> pend_cnt stays 3, no overflow.
- rst asserted mid-window at tap_idx=4 with pend_cnt=2 -> next cycle all outputs 0, IDLE; later pulses are processed normally.

Source files
------------

// File: rtl/pulse_tap_sequencer.sv
// Turns each window-ready pulse into a burst of NUM_TAPS tap-index beats.
// Pulses that arrive mid-burst queue in a saturating counter and launch back-to-back.
module pulse_tap_sequencer #(
    parameter int NUM_TAPS = 9,
    parameter int TAP_W    = 4,
    parameter int PEND_W   = 4
) (
    input  logic              fast_clk,
    input  logic              rst,
    input  logic              fast_pulse,
    input  logic              enable,
    input  logic              ovf_clr,
    output logic              tap_valid,
    output logic [TAP_W-1:0]  tap_idx,
    output logic              tap_first,
    output logic              tap_last,
    output logic              win_done,
    output logic [PEND_W-1:0] pend_cnt,
    output logic              overflow
);
    // state | meaning
    // IDLE  | no window in flight; launches when a window is queued and enable=1
    // RUN   | issuing beats of the current window; stalls while enable=0
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [TAP_W-1:0]  LAST_TAP = TAP_W'(NUM_TAPS - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    state_t            state;
    state_t            state_nxt;
    logic [TAP_W-1:0]  tap_idx_nxt;
    logic [PEND_W-1:0] pend_nxt;
    logic              win_done_nxt;
    logic              start;
    logic              inc;
    logic              drop;

    always_ff @(posedge fast_clk) begin
        if (rst) begin
            state    <= IDLE;
            tap_idx  <= '0;
            pend_cnt <= '0;
            win_done <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            tap_idx  <= tap_idx_nxt;
            pend_cnt <= pend_nxt;
            win_done <= win_done_nxt;
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        tap_idx_nxt  = tap_idx;
        win_done_nxt = 1'b0;
        start        = 1'b0;
        case (state)
            IDLE: begin
                if (pend_cnt != '0 && enable) begin
                    state_nxt   = RUN;
                    tap_idx_nxt = '0;
                    start       = 1'b1;
                end
            end
            RUN: begin
                if (enable) begin
                    if (tap_idx == LAST_TAP) begin
                        win_done_nxt = 1'b1;
                        tap_idx_nxt  = '0;
                        if (pend_cnt != '0) begin
                            start = 1'b1;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        tap_idx_nxt = tap_idx + TAP_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // A launch frees a slot, so a pulse at full count is only dropped without one.
        inc      = fast_pulse && !(pend_cnt == PEND_MAX && !start);
        drop     = fast_pulse && !inc;
        pend_nxt = pend_cnt + PEND_W'(inc) - PEND_W'(start);
    end

    always_comb begin
        tap_valid = (state == RUN) && enable;
        tap_first = tap_valid && (tap_idx == '0);
        tap_last  = tap_valid && (tap_idx == LAST_TAP);
    end
endmodule

// File: tb/tb_pulse_tap_sequencer.sv
// Bench for pulse_tap_sequencer: a 9-tap/4-bit-queue instance and a 1-tap/2-bit-queue
// instance share stimulus; directed scenarios plus a random run against a reference model.
module tb_pulse_tap_sequencer;
    localparam int A_TAPS = 9;
    localparam int A_TW   = 4;
    localparam int A_PW   = 4;
    localparam int B_TAPS = 1;
    localparam int B_TW   = 1;
    localparam int B_PW   = 2;

    logic fast_clk = 1'b0;
    logic rst, fast_pulse, enable, ovf_clr;

    logic            a_valid, a_first, a_last, a_done, a_ovf;
    logic [A_TW-1:0] a_idx;
    logic [A_PW-1:0] a_pend;
    logic            b_valid, b_first, b_last, b_done, b_ovf;
    logic [B_TW-1:0] b_idx;
    logic [B_PW-1:0] b_pend;

    int n_pass  = 0;
    int n_total = 0;

    always #5 fast_clk = ~fast_clk;

    pulse_tap_sequencer #(.NUM_TAPS(A_TAPS), .TAP_W(A_TW), .PEND_W(A_PW)) dut_a (
        .fast_clk(fast_clk), .rst(rst), .fast_pulse(fast_pulse), .enable(enable),
        .ovf_clr(ovf_clr), .tap_valid(a_valid), .tap_idx(a_idx), .tap_first(a_first),
        .tap_last(a_last), .win_done(a_done), .pend_cnt(a_pend), .overflow(a_ovf)
    );

    pulse_tap_sequencer #(.NUM_TAPS(B_TAPS), .TAP_W(B_TW), .PEND_W(B_PW)) dut_b (
        .fast_clk(fast_clk), .rst(rst), .fast_pulse(fast_pulse), .enable(enable),
        .ovf_clr(ovf_clr), .tap_valid(b_valid), .tap_idx(b_idx), .tap_first(b_first),
        .tap_last(b_last), .win_done(b_done), .pend_cnt(b_pend), .overflow(b_ovf)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge fast_clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; fast_pulse = 1'b0; enable = 1'b0; ovf_clr = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        enable = 1'b1;
        settle();
        n_total++;
        if ({a_valid, a_idx, a_first, a_last, a_done, a_pend, a_ovf} !== '0)
            $display("FAIL reset_a: got v=%b idx=%0d f=%b l=%b d=%b p=%0d o=%b, want all 0",
                     a_valid, a_idx, a_first, a_last, a_done, a_pend, a_ovf);
        else n_pass++;
        n_total++;
        if ({b_valid, b_idx, b_first, b_last, b_done, b_pend, b_ovf} !== '0)
            $display("FAIL reset_b: got v=%b idx=%0d f=%b l=%b d=%b p=%0d o=%b, want all 0",
                     b_valid, b_idx, b_first, b_last, b_done, b_pend, b_ovf);
        else n_pass++;
    endtask

    task automatic test_single();
        do_reset();
        enable = 1'b1;
        fast_pulse = 1'b1;
        tick();
        fast_pulse = 1'b0;
        settle();
        n_total++;
        if (a_pend !== A_PW'(1) || a_valid !== 1'b0)
            $display("FAIL single_latency: got pend=%0d valid=%b, want pend=1 valid=0", a_pend, a_valid);
        else n_pass++;
        for (int k = 2; k <= 10; k++) begin
            tick();
            n_total++;
            if (a_valid !== 1'b1 || a_idx !== A_TW'(k - 2) || a_first !== (k == 2) || a_last !== (k == 10))
                $display("FAIL single_beat cyc=%0d: got v=%b idx=%0d f=%b l=%b, want v=1 idx=%0d f=%b l=%b",
                         k, a_valid, a_idx, a_first, a_last, k - 2, (k == 2), (k == 10));
            else n_pass++;
        end
        tick();
        n_total++;
        if (a_done !== 1'b1 || a_valid !== 1'b0 || a_pend !== '0)
            $display("FAIL single_done: got d=%b v=%b p=%0d, want d=1 v=0 p=0", a_done, a_valid, a_pend);
        else n_pass++;
        tick();
        n_total++;
        if (a_done !== 1'b0 || a_valid !== 1'b0)
            $display("FAIL single_idle: got d=%b v=%b, want d=0 v=0", a_done, a_valid);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int beats, dones, peak, first_cyc, last_cyc;
        bit seq_ok;
        beats = 0; dones = 0; peak = 0; first_cyc = -1; last_cyc = -1; seq_ok = 1'b1;
        do_reset();
        enable = 1'b1;
        for (int c = 0; c < 45; c++) begin
            fast_pulse = (c < 3);
            settle();
            if (a_valid) begin
                if (first_cyc < 0) first_cyc = c;
                last_cyc = c;
                if (a_idx !== A_TW'(beats % 9) || a_first !== (beats % 9 == 0)
                    || a_last !== (beats % 9 == 8)) seq_ok = 1'b0;
                beats++;
            end
            if (a_done === 1'b1) dones++;
            if (int'(a_pend) > peak) peak = int'(a_pend);
            tick();
        end
        fast_pulse = 1'b0;
        settle();
        n_total++;
        if (beats != 27 || last_cyc - first_cyc != 26)
            $display("FAIL b2b_beats: got beats=%0d span=%0d, want 27 and 26", beats, last_cyc - first_cyc);
        else n_pass++;
        n_total++;
        if (!seq_ok) $display("FAIL b2b_sequence: got bad idx/first/last pattern, want 0..8 x3");
        else n_pass++;
        n_total++;
        if (dones != 3 || peak != 2)
            $display("FAIL b2b_done_peak: got dones=%0d peak=%0d, want 3 and 2", dones, peak);
        else n_pass++;
        n_total++;
        if (a_valid !== 1'b0 || a_pend !== '0)
            $display("FAIL b2b_end: got v=%b p=%0d, want v=0 p=0", a_valid, a_pend);
        else n_pass++;
    endtask

    task automatic test_stall();
        int beats;
        bit found, done;
        beats = 0; found = 1'b0; done = 1'b0;
        do_reset();
        enable = 1'b1;
        fast_pulse = 1'b1;
        tick();
        fast_pulse = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            settle();
            if (a_valid === 1'b1 && a_idx === A_TW'(5)) found = 1'b1;
            else begin
                if (a_valid === 1'b1) beats++;
                tick();
            end
        end
        n_total++;
        if (!found) $display("FAIL stall_reach: got no beat at idx 5, want one within 20 cycles");
        else n_pass++;
        enable = 1'b0;
        for (int c = 0; c < 4; c++) begin
            settle();
            n_total++;
            if (a_valid !== 1'b0 || a_idx !== A_TW'(5))
                $display("FAIL stall_hold c=%0d: got v=%b idx=%0d, want v=0 idx=5", c, a_valid, a_idx);
            else n_pass++;
            tick();
        end
        enable = 1'b1;
        settle();
        n_total++;
        if (a_valid !== 1'b1 || a_idx !== A_TW'(5))
            $display("FAIL stall_resume: got v=%b idx=%0d, want v=1 idx=5", a_valid, a_idx);
        else n_pass++;
        for (int c = 0; c < 20 && !done; c++) begin
            settle();
            if (a_valid === 1'b1) beats++;
            tick();
            if (a_done === 1'b1) done = 1'b1;
        end
        n_total++;
        if (!done || beats != 9)
            $display("FAIL stall_total: got done=%b beats=%0d, want done=1 beats=9", done, beats);
        else n_pass++;
    endtask

    task automatic test_overflow();
        do_reset();
        for (int c = 0; c < 5; c++) begin
            fast_pulse = 1'b1;
            tick();
        end
        fast_pulse = 1'b0;
        settle();
        n_total++;
        if (b_pend !== B_PW'(3) || b_ovf !== 1'b1)
            $display("FAIL ovf_saturate: got p=%0d o=%b, want p=3 o=1", b_pend, b_ovf);
        else n_pass++;
        n_total++;
        if (a_pend !== A_PW'(5) || a_ovf !== 1'b0)
            $display("FAIL ovf_wide_queue: got p=%0d o=%b, want p=5 o=0", a_pend, a_ovf);
        else n_pass++;
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        settle();
        n_total++;
        if (b_ovf !== 1'b0 || b_pend !== B_PW'(3))
            $display("FAIL ovf_clear: got o=%b p=%0d, want o=0 p=3", b_ovf, b_pend);
        else n_pass++;
        fast_pulse = 1'b1;
        ovf_clr = 1'b1;
        tick();
        fast_pulse = 1'b0;
        ovf_clr = 1'b0;
        settle();
        n_total++;
        if (b_ovf !== 1'b1 || b_pend !== B_PW'(3))
            $display("FAIL ovf_drop_priority: got o=%b p=%0d, want o=1 p=3", b_ovf, b_pend);
        else n_pass++;
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        settle();
        n_total++;
        if (b_ovf !== 1'b0) $display("FAIL ovf_reclear: got o=%b, want o=0", b_ovf);
        else n_pass++;
    endtask

    // Continues from test_overflow: dut_b idle with a full queue and overflow cleared.
    task automatic test_simultaneous();
        bit drained;
        drained = 1'b0;
        enable = 1'b1;
        fast_pulse = 1'b1;
        settle();
        n_total++;
        if (b_valid !== 1'b0) $display("FAIL simul_idle: got v=%b, want v=0", b_valid);
        else n_pass++;
        tick();
        n_total++;
        if (b_pend !== B_PW'(3) || b_ovf !== 1'b0 || b_valid !== 1'b1 || b_idx !== '0
            || b_first !== 1'b1 || b_last !== 1'b1)
            $display("FAIL simul_launch: got p=%0d o=%b v=%b idx=%0d f=%b l=%b, want p=3 o=0 v=1 idx=0 f=1 l=1",
                     b_pend, b_ovf, b_valid, b_idx, b_first, b_last);
        else n_pass++;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_total++;
            if (b_pend !== B_PW'(3) || b_ovf !== 1'b0 || b_valid !== 1'b1 || b_first !== 1'b1
                || b_last !== 1'b1 || b_done !== 1'b1)
                $display("FAIL simul_run c=%0d: got p=%0d o=%b v=%b f=%b l=%b d=%b, want p=3 o=0 v=1 f=1 l=1 d=1",
                         c, b_pend, b_ovf, b_valid, b_first, b_last, b_done);
            else n_pass++;
        end
        fast_pulse = 1'b0;
        for (int c = 0; c < 10 && !drained; c++) begin
            tick();
            if (b_pend === '0 && b_valid === 1'b0) drained = 1'b1;
        end
        n_total++;
        if (!drained) $display("FAIL simul_drain: got p=%0d v=%b, want p=0 v=0", b_pend, b_valid);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int beats;
        bit found, done;
        beats = 0; found = 1'b0; done = 1'b0;
        do_reset();
        enable = 1'b1;
        for (int c = 0; c < 3; c++) begin
            fast_pulse = 1'b1;
            tick();
        end
        fast_pulse = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            settle();
            if (a_valid === 1'b1 && a_idx === A_TW'(4)) found = 1'b1;
            else tick();
        end
        n_total++;
        if (!found || a_pend !== A_PW'(2))
            $display("FAIL rstmid_setup: got found=%b p=%0d, want found=1 p=2", found, a_pend);
        else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        n_total++;
        if ({a_valid, a_idx, a_first, a_last, a_done, a_pend, a_ovf} !== '0)
            $display("FAIL rstmid_clear: got v=%b idx=%0d f=%b l=%b d=%b p=%0d o=%b, want all 0",
                     a_valid, a_idx, a_first, a_last, a_done, a_pend, a_ovf);
        else n_pass++;
        fast_pulse = 1'b1;
        tick();
        fast_pulse = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            settle();
            if (a_valid === 1'b1) beats++;
            tick();
            if (a_done === 1'b1) done = 1'b1;
        end
        n_total++;
        if (!done || beats != 9)
            $display("FAIL rstmid_after: got done=%b beats=%0d, want done=1 beats=9", done, beats);
        else n_pass++;
    endtask

    // Reference model: per instance, whether a window is open, which beat is next,
    // queued windows, sticky overflow and the done flag.
    task automatic test_random();
        int  ntap[2];
        int  pmax[2];
        int  m_win[2], m_beat[2], m_pend[2], m_ovf[2], m_done[2];
        bit  beat_now, last, launch, accept, ev, ef, el;
        int  errs_a, errs_b;
        ntap = '{A_TAPS, B_TAPS};
        pmax = '{(1 << A_PW) - 1, (1 << B_PW) - 1};
        errs_a = 0; errs_b = 0;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            m_win[k] = 0; m_beat[k] = 0; m_pend[k] = 0; m_ovf[k] = 0; m_done[k] = 0;
        end
        for (int c = 0; c < 3000; c++) begin
            rst        = ($urandom_range(0, 249) == 0);
            fast_pulse = ((c / 300) % 2 == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
            enable     = ((c / 200) % 3 == 2) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0);
            ovf_clr    = ($urandom_range(0, 31) == 0);
            settle();

            ev = (m_win[0] != 0) && enable;
            ef = ev && (m_beat[0] == 0);
            el = ev && (m_beat[0] == ntap[0] - 1);
            n_total++;
            if (a_valid !== ev || a_idx !== A_TW'(m_beat[0]) || a_first !== ef || a_last !== el
                || a_done !== (m_done[0] != 0) || a_pend !== A_PW'(m_pend[0]) || a_ovf !== (m_ovf[0] != 0)) begin
                if (errs_a < 5)
                    $display("FAIL random_a cyc=%0d: got v=%b idx=%0d f=%b l=%b d=%b p=%0d o=%b, want v=%b idx=%0d f=%b l=%b d=%0d p=%0d o=%0d",
                             c, a_valid, a_idx, a_first, a_last, a_done, a_pend, a_ovf,
                             ev, m_beat[0], ef, el, m_done[0], m_pend[0], m_ovf[0]);
                errs_a++;
            end else n_pass++;

            ev = (m_win[1] != 0) && enable;
            ef = ev && (m_beat[1] == 0);
            el = ev && (m_beat[1] == ntap[1] - 1);
            n_total++;
            if (b_valid !== ev || b_idx !== B_TW'(m_beat[1]) || b_first !== ef || b_last !== el
                || b_done !== (m_done[1] != 0) || b_pend !== B_PW'(m_pend[1]) || b_ovf !== (m_ovf[1] != 0)) begin
                if (errs_b < 5)
                    $display("FAIL random_b cyc=%0d: got v=%b idx=%0d f=%b l=%b d=%b p=%0d o=%b, want v=%b idx=%0d f=%b l=%b d=%0d p=%0d o=%0d",
                             c, b_valid, b_idx, b_first, b_last, b_done, b_pend, b_ovf,
                             ev, m_beat[1], ef, el, m_done[1], m_pend[1], m_ovf[1]);
                errs_b++;
            end else n_pass++;

            for (int k = 0; k < 2; k++) begin
                if (rst) begin
                    m_win[k] = 0; m_beat[k] = 0; m_pend[k] = 0; m_ovf[k] = 0; m_done[k] = 0;
                end else begin
                    beat_now = (m_win[k] != 0) && enable;
                    last     = beat_now && (m_beat[k] == ntap[k] - 1);
                    launch   = ((m_win[k] == 0) && m_pend[k] > 0 && enable) || (last && m_pend[k] > 0);
                    accept   = fast_pulse && (m_pend[k] < pmax[k] || launch);
                    if (fast_pulse && !accept) m_ovf[k] = 1;
                    else if (ovf_clr) m_ovf[k] = 0;
                    m_pend[k] = m_pend[k] + int'(accept) - int'(launch);
                    m_done[k] = int'(last);
                    if (launch) begin
                        m_win[k] = 1; m_beat[k] = 0;
                    end else if (last) begin
                        m_win[k] = 0; m_beat[k] = 0;
                    end else if (beat_now) begin
                        m_beat[k] = m_beat[k] + 1;
                    end
                end
            end
            tick();
        end
        rst = 1'b0; fast_pulse = 1'b0; enable = 1'b0; ovf_clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; fast_pulse = 1'b0; enable = 1'b0; ovf_clr = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_overflow();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
